siso_tx_scheduler: RTL
======================

// Module: siso_tx_scheduler
// PURPOSE
//   Shares one WIDTH-bit serial-out shift path between two parallel-word requesters.
//   Round-robin arbitration grants one requester, loads its word, shifts it out MSB-first
//   on so, then inserts an idle gap of GAP_CYCLES cycles before the next grant.
//   Sits in front of the serial link that the SISO shift register drives.
// PARAMETERS
//   WIDTH       4   bits per frame (>=2)
//   GAP_CYCLES  1   idle cycles between frames (0 = back-to-back)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst          in   1      synchronous, active-high reset
//   req0_valid   in   1      requester 0 holds a word
//   req0_data    in   WIDTH  requester 0 word
//   req0_ready   out  1      handshake to requester 0 (word taken when valid&&ready)
//   req1_valid   in   1      requester 1 holds a word
//   req1_data    in   WIDTH  requester 1 word
//   req1_ready   out  1      handshake to requester 1
//   so           out  1      serial data out
//   so_valid     out  1      so carries a frame bit this cycle
//   sof          out  1      first bit of frame (with so_valid)
//   eof          out  1      last bit of frame (with so_valid)
//   grant_id     out  1      owner of current frame, meaningful while so_valid=1
//   busy         out  1      state != IDLE
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, shift reg=0, bit count=0, gap count=0,
//     last_grant=1 (req0 wins first tie); so=0, so_valid=0, sof=0, eof=0, grant_id=0,
//     busy=0, both ready=0. Reset mid-frame aborts the frame; no bits resume.
//   - States: IDLE, SHIFT, GAP.
//   - IDLE: readyN combinational = (state==IDLE) && (grant==N). Grant: only one valid ->
//     that one; both valid -> the one != last_grant. Never both ready in one cycle.
//     On handshake: load data into shift reg, set grant_id and last_grant, bit count=0,
//     go SHIFT. No valid -> stay IDLE.
//   - Latency: handshake at posedge k -> first bit on so in cycle after k (so_valid=1, sof=1).
//   - SHIFT: so = shift reg MSB; shift left by 1 each cycle, LSB fills 0; exactly WIDTH
//     cycles with so_valid=1; eof=1 on bit WIDTH-1. After last bit: GAP if GAP_CYCLES>0,
//     else IDLE.
//   - GAP: so_valid=0, so=0, count GAP_CYCLES cycles, then IDLE.
//   - GAP_CYCLES=0 with continuous valids: one IDLE (handshake) cycle between frames, so
//     frame period = WIDTH+1 cycles; with gap, WIDTH+GAP_CYCLES+1.
//   - so=0, sof=0, eof=0 whenever so_valid=0. sof and eof never both 1 (WIDTH>=2).
//   - Requester valid/data must hold until handshake; data sampled only on handshake;
//     changes to req data during SHIFT/GAP have no effect.
//   - Valid dropped before handshake: no grant issued, last_grant unchanged.
//   - busy=1 in SHIFT and GAP, 0 in IDLE.
// TESTING
//   1. rst 2 cycles; req0_valid=1, data=4'b1011 -> req0_ready 1-cycle pulse; so=1,0,1,1
//      with so_valid 4 cycles, sof on 1st, eof on 4th, grant_id=0; then 1 gap cycle.
//   2. Both valid from reset, req0=4'hA, req1=4'h5 held -> frames A(id0), 5(id1), A(id0)...
//      strict alternation, each frame 4 bits, period 6 cycles with GAP_CYCLES=1.
//   3. rst=1 during 3rd bit of a frame -> next cycle so_valid=0, busy=0, outputs 0;
//      after rst=0 with req1 valid, req1 is not preferred over req0 (last_grant=1).
//   4. GAP_CYCLES=0, req1 only, continuous -> so_valid pattern 1111 0 1111 0 ...
//   5. req0_valid toggled low before grant, data changed during SHIFT -> serialized word
//      equals data at handshake; no ready asserted while valid=0.
//   6. No requests for 20 cycles after reset -> busy=0, so_valid=0, so=0 throughout.

Source files
------------

// File: rtl/siso_tx_scheduler.sv
// Round-robin scheduler that shares one MSB-first serial shift path between two
// parallel-word requesters, with an optional idle gap between frames.
module siso_tx_scheduler #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             sof,
  output logic             eof,
  output logic             grant_id,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             take;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid)
      grant = ~last_grant;
    else if (req1_valid)
      grant = 1'b1;
    take       = (state == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = take && !grant;
    req1_ready = take && grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            shreg      <= grant ? req1_data : req0_data;
            owner      <= grant;
            last_grant <= grant;
            bitcnt     <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (bitcnt == BIT_LAST) begin
            bitcnt <= '0;
            gapcnt <= '0;
            state  <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        GAP: begin
          if (gapcnt == GAP_LAST)
            state <= IDLE;
          else
            gapcnt <= gapcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame markers are forced low outside SHIFT so the link sees clean zeros.
  always_comb begin
    so_valid = (state == SHIFT);
    so       = so_valid && shreg[WIDTH-1];
    sof      = so_valid && (bitcnt == '0);
    eof      = so_valid && (bitcnt == BIT_LAST);
    grant_id = owner;
    busy     = (state != IDLE);
  end

endmodule
